// File: rtl/ram_loader.sv
// Boot loader: streams bytes into the data RAM from address 0 and holds the CPU until done.
// Define RAM_LOADER_VERIFY_EN to add XOR-checksum readback (RAM read data expected the cycle after its address).
module ram_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_input_data,
    input  logic [DATA_W-1:0] ram_output_data,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
`ifdef RAM_LOADER_VERIFY_EN
        , VERIFY
`endif
    } state_t;

    state_t          state;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] ptr;

`ifdef RAM_LOADER_VERIFY_EN
    logic [ADDR_W:0]   rptr;
    logic              rd_v;
    logic [DATA_W-1:0] sum_w;
    logic [DATA_W-1:0] sum_r;
`else
    logic unused_rd;
    assign unused_rd = ^ram_output_data;
    assign error     = 1'b0;
`endif

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            len              <= '0;
            ptr              <= '0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            ram_input_data   <= '0;
            done             <= 1'b0;
            cpu_hold         <= 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
            rptr             <= '0;
            rd_v             <= 1'b0;
            sum_w            <= '0;
            sum_r            <= '0;
            error            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done             <= 1'b0;
                    ram_write_enable <= 1'b0;
                    if (start) begin
                        len      <= (length > DEPTH) ? DEPTH : length;
                        ptr      <= '0;
                        cpu_hold <= 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
                        rptr     <= '0;
                        rd_v     <= 1'b0;
                        sum_w    <= '0;
                        sum_r    <= '0;
                        error    <= 1'b0;
`endif
                        state    <= (length == '0) ? FINISH : LOAD;
                    end
                end
                LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid alone marks an accept
                    ram_write_enable <= in_valid;
                    if (in_valid) begin
                        ram_address    <= ptr[ADDR_W-1:0];
                        ram_input_data <= in_data;
                        ptr            <= ptr + 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
                        sum_w          <= sum_w ^ in_data;
                        if (ptr == len - 1'b1)
                            state <= VERIFY;
`else
                        if (ptr == len - 1'b1)
                            state <= FINISH;
`endif
                    end
                end
`ifdef RAM_LOADER_VERIFY_EN
                VERIFY: begin
                    // first VERIFY cycle still carries the final write; reads start after it
                    ram_write_enable <= 1'b0;
                    if (rd_v)
                        sum_r <= sum_r ^ ram_output_data;
                    if (rptr < len) begin
                        ram_address <= rptr[ADDR_W-1:0];
                        rptr        <= rptr + 1'b1;
                        rd_v        <= 1'b1;
                    end else begin
                        rd_v <= 1'b0;
                    end
                    if (rd_v && (rptr == len)) begin
                        error <= ((sum_r ^ ram_output_data) != sum_w);
                        state <= FINISH;
                    end
                end
`endif
                FINISH: begin
                    ram_write_enable <= 1'b0;
                    done             <= 1'b1;
                    cpu_hold         <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: a cycle model of the loader rules is checked every cycle,
// plus literal checks of RAM contents, done timing and error flag.
module tb_ram_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] length;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ram_write_enable;
    logic [5:0] ram_address;
    logic [7:0] ram_input_data;
    logic [7:0] ram_output_data;
    logic       busy;
    logic       done;
    logic       cpu_hold;
    logic       error;

    logic       corrupt;
    logic [5:0] corrupt_addr;
    logic [7:0] tbmem [64];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int wr_last = -1;
    int done_cnt = 0;

`ifdef RAM_LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    ram_loader #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .length           (length),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_input_data   (ram_input_data),
        .ram_output_data  (ram_output_data),
        .busy             (busy),
        .done             (done),
        .cpu_hold         (cpu_hold),
        .error            (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment RAM: synchronous write, combinational read
    always @(posedge clk) begin
        if (ram_write_enable)
            tbmem[ram_address] <= ram_input_data;
        if (corrupt)
            tbmem[corrupt_addr] <= tbmem[corrupt_addr] ^ 8'hFF;
    end
    assign ram_output_data = tbmem[ram_address];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: expected outputs for the current cycle plus what the loader has still to do
    logic       e_we, e_done, e_hold, e_err;
    logic [5:0] e_addr;
    logic [7:0] e_data;
    int         ld_left, acc, vk, vlen;
    bit         vph, fin;
    logic [7:0] sw, sr;

    initial begin
        e_we = 0; e_done = 0; e_hold = 1; e_err = 0; e_addr = 0; e_data = 0;
        ld_left = 0; acc = 0; vk = 0; vlen = 0; vph = 0; fin = 0; sw = 0; sr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_we = 0; e_done = 0; e_hold = 1; e_err = 0; e_addr = 0; e_data = 0;
                ld_left = 0; vph = 0; fin = 0;
            end
            chk("ram_write_enable", ram_write_enable, e_we);
            chk("ram_address", ram_address, e_addr);
            chk("ram_input_data", ram_input_data, e_data);
            chk("busy", busy, (ld_left > 0) || vph || fin);
            chk("in_ready", in_ready, ld_left > 0);
            chk("done", done, e_done);
            chk("cpu_hold", cpu_hold, e_hold);
            chk("error", error, e_err);
            if (ram_write_enable) begin
                wr_cnt++;
                wr_last = int'(ram_address);
            end
            if (done) done_cnt++;
            if (rst_n) begin
                e_we = 0;
                e_done = 0;
                if (fin) begin
                    e_done = 1; e_hold = 0; fin = 0;
                end else if (vph) begin
                    if (vk >= 1) sr = sr ^ tbmem[vk-1];
                    if (vk < vlen) e_addr = 6'(vk);
                    if (vk == vlen) begin
                        e_err = (sr != sw); vph = 0; fin = 1;
                    end
                    vk++;
                end else if (ld_left > 0) begin
                    if (in_valid) begin
                        e_we = 1; e_addr = 6'(acc); e_data = in_data;
                        sw = sw ^ in_data; acc++; ld_left--;
                        if (ld_left == 0) begin
                            if (VER) begin vph = 1; vk = 0; vlen = acc; end
                            else fin = 1;
                        end
                    end
                end else if (start) begin
                    e_hold = 1; e_err = 0; sw = 0; sr = 0; acc = 0;
                    if (length == 0) fin = 1;
                    else ld_left = (length > 64) ? 64 : int'(length);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int l);
        start = 1'b1;
        length = 7'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_within_budget", seen, 1);
    endtask

    initial begin
        int d0, w0;
        rst_n = 1'b0; start = 0; length = 0; in_valid = 0; in_data = 0;
        corrupt = 0; corrupt_addr = 0;
        for (int i = 0; i < 64; i++) tbmem[i] = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("idle_cpu_hold", cpu_hold, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_we", ram_write_enable, 0);
        chk("idle_addr", ram_address, 0);

        // Three bytes back to back
        tick();
        d0 = done_cnt;
        start_load(3);
        send(8'h0A); send(8'h14); send(8'h1E);
        wait_done(20);
        chk("hold_drop_at_done", cpu_hold, 0);
        repeat (3) tick();
        chk("done_pulses", done_cnt - d0, 1);
        chk("mem0", tbmem[0], 8'h0A);
        chk("mem1", tbmem[1], 8'h14);
        chk("mem2", tbmem[2], 8'h1E);

        // Full depth with a gap after every byte
        w0 = wr_cnt;
        start_load(64);
        for (int i = 0; i < 64; i++) begin
            send(8'(i));
            tick();
        end
        wait_done(200);
        chk("full_write_count", wr_cnt - w0, 64);
        chk("full_last_addr", wr_last, 63);
        chk("full_mem63", tbmem[63], 8'd63);
        chk("full_mem17", tbmem[17], 8'd17);

        // Zero length: no writes, done two cycles after start
        tick();
        w0 = wr_cnt;
        start_load(0);
        @(negedge clk);
        chk("len0_done_early", done, 0);
        @(negedge clk);
        chk("len0_done_at_2", done, 1);
        chk("len0_no_write", wr_cnt - w0, 0);

`ifdef RAM_LOADER_VERIFY_EN
        // Corrupted word is caught; clean rerun passes
        tick();
        start_load(4);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        corrupt = 1'b1; corrupt_addr = 6'd2;
        tick();
        corrupt = 1'b0;
        wait_done(30);
        chk("verify_bad_error", error, 1);
        tick();
        start_load(4);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_done(30);
        chk("verify_clean_error", error, 0);
`endif

        // Reset in the middle of a load
        tick();
        start_load(5);
        send(8'hA1); send(8'hA2);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_we", ram_write_enable, 0);
        chk("abort_hold", cpu_hold, 1);
        chk("abort_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_load(3);
        send(8'h55); send(8'h66); send(8'h77);
        wait_done(30);
        repeat (2) tick();
        chk("reload_mem0", tbmem[0], 8'h55);
        chk("reload_mem1", tbmem[1], 8'h66);
        chk("reload_mem2", tbmem[2], 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Boot-time program/data loader sitting directly upstream of the 64x8 data RAM in the single-cycle accumulator processor.
- Accepts a byte stream over a valid/ready handshake and writes it sequentially into RAM from address 0 through the RAM's write_enable/address/input_data port.
- Holds the CPU stalled until the image is in place.
- Optionally reads the image back and checks it against an XOR checksum.

Parameters:
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM word width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a load; sampled only in IDLE
- length  input  ADDR_W+1  number of words to load (0..2**ADDR_W), sampled with start
- in_valid  input  1  upstream byte valid
- in_data  input  DATA_W  upstream byte
- in_ready  output  1  loader can accept a byte this cycle
- ram_write_enable  output  1  to RAM write_enable
- ram_address  output  ADDR_W  to RAM address
- ram_input_data  output  DATA_W  to RAM input_data
- ram_output_data  input  DATA_W  from RAM output_data (used only with verify)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a load (and verify) completes
- cpu_hold  output  1  stalls the processor
- error  output  1  verify mismatch flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all counters, checksums and RAM outputs cleared.
  - ram_write_enable=0, ram_address=0, ram_input_data=0.
  - busy=0, done=0, error=0, in_ready=0.
  - cpu_hold=1: the CPU stays stalled after reset until the first done.
- States: IDLE, LOAD, VERIFY (macro only), FINISH.
- IDLE:
  - start=1 latches len = min(length, 2**ADDR_W) and clears ptr, sum_w, sum_r and error.
  - Sets cpu_hold=1.
  - len=0 goes to FINISH; otherwise goes to LOAD.
- LOAD:
  - in_ready=1, driven combinationally from state.
  - Accept occurs when in_valid & in_ready.
  - Outputs are registered: the cycle after an accept, ram_write_enable=1, ram_address=ptr and ram_input_data=byte.
  - ptr increments on each accept; sum_w ^= byte.
  - Throughput is one byte per cycle; in_valid gaps produce ram_write_enable=0 cycles.
  - The accept of byte len-1 moves the state to VERIFY (if enabled) or FINISH.
  - in_ready is 0 from the following cycle; that cycle still carries the final write.
- VERIFY:
  - ram_write_enable=0; ram_address steps from 0 to len-1, one per cycle.
  - ram_output_data is sampled one cycle after its address is driven: sum_r ^= data.
  - After the last sample, error = (sum_r != sum_w), then go to FINISH.
- FINISH:
  - done=1 for exactly one cycle; cpu_hold drops to 0 in the same cycle.
  - Returns to IDLE the next cycle.
  - error holds its value until the next start.
- start outside IDLE is ignored.
- ram_address never exceeds len-1, and there is no wrap, because len is clamped.
- rst_n asserted mid-load: the load is aborted immediately. RAM contents already written are not restored. cpu_hold=1.
- busy = (state != IDLE).

Optional Feature:
- Macro: RAM_LOADER_VERIFY_EN.
- Defined: the VERIFY state, sum_w/sum_r logic and error flag are compiled in. Load-to-done latency is len (accept cycles) + len + 2 cycles.
- Undefined: no VERIFY state; LOAD goes straight to FINISH; error is tied to 0; ram_output_data is unused.

Test Plan:
- Reset then idle 5 cycles -> cpu_hold=1, busy=0, done=0, ram_write_enable=0, ram_address=0.
- start with length=3; stream 0x0A, 0x14, 0x1E with in_valid held high -> writes addr0=0x0A, addr1=0x14, addr2=0x1E on consecutive cycles; done pulses once; cpu_hold falls; RAM reads back 0x0A/0x14/0x1E.
- length=64, in_valid toggling every other cycle, data = address -> 64 writes covering 0..63 with no address 64/wrap; in_ready=0 after the 64th accept.
- length=0 -> no ram_write_enable pulse; done asserted 2 cycles after start.
- Verify build: load 4 bytes, force RAM word 2 corrupt before readback -> error=1 at done; clean rerun -> error=0.
- rst_n low after 2 of 5 bytes accepted -> immediately IDLE, in_ready=0, ram_write_enable=0, cpu_hold=1; a new start afterwards loads correctly from address 0.
